// File: rtl/ula_opr_stage.sv
// ula_opr_stage: operand-issue stage in front of the processor ALU.
//   Holds the accumulator and an operand stack for nested expressions.
//   It registers op/in1/in2 toward the ALU and captures the ALU result and
//   zero flag back into the accumulator. Stack overflow and underflow raise
//   sticky flags.
//
// Parameters:
//   EXP, MAN  exponent and mantissa widths; the data word is MAN+EXP+1 bits
//   SDEPTH    operand stack depth in words (2..64)
//   SPTR      stack index width; 2**SPTR must be >= SDEPTH
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   iss_vld         the decoder issues an instruction this cycle
//   op_in           ALU opcode to issue
//   src_sel         in2 source: 0 = mem_in, 1 = pop the stack top
//   mem_in          memory/immediate operand
//   push            push acc onto the stack (qualified by iss_vld)
//   ula_out         ALU result
//   ula_zero        ALU zero flag
//   acc_wr          capture ula_out/ula_zero into acc
//   op, in1, in2    registered operands toward the ALU
//   opr_vld         op/in1/in2 valid (one cycle per issue)
//   acc, acc_zero   accumulator and its registered zero flag
//   stk_full        combinational: sp == SDEPTH
//   stk_empty       combinational: sp == 0
//   stk_ovf         sticky flag: push on a full stack
//   stk_unf         sticky flag: pop on an empty stack
//   stk_hwm         highest sp reached since reset (only when ULA_STK_HWM_EN
//                   is defined)
//
// Optional build macro: ULA_STK_HWM_EN adds the stk_hwm output and its logic.

module ula_opr_stage #(
  parameter int unsigned EXP    = 8,
  parameter int unsigned MAN    = 23,
  parameter int unsigned SDEPTH = 8,
  parameter int unsigned SPTR   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_vld,
  input  logic [5:0]           op_in,
  input  logic                 src_sel,
  input  logic [MAN+EXP:0]     mem_in,
  input  logic                 push,
  input  logic [MAN+EXP:0]     ula_out,
  input  logic                 ula_zero,
  input  logic                 acc_wr,
  output logic [5:0]           op,
  output logic [MAN+EXP:0]     in1,
  output logic [MAN+EXP:0]     in2,
  output logic                 opr_vld,
  output logic [MAN+EXP:0]     acc,
  output logic                 acc_zero,
  output logic                 stk_full,
  output logic                 stk_empty,
  output logic                 stk_ovf,
  output logic                 stk_unf
`ifdef ULA_STK_HWM_EN
  ,
  output logic [SPTR:0]        stk_hwm
`endif
);

  localparam int unsigned W    = MAN + EXP + 1;
  localparam int unsigned SP_W = SPTR + 1;

  // Stack storage; its contents are not reset.
  logic [W-1:0]      stk_mem [SDEPTH];

  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_nxt;
  logic              ovf_nxt;
  logic              unf_nxt;
  logic              wr_en;
  logic [SPTR-1:0]   wr_idx;
  logic [SPTR-1:0]   top_idx;
  logic [W-1:0]      top_val;
  logic [W-1:0]      in2_nxt;
  logic              do_push;
  logic              do_pop;
  logic              do_rep;

  // Occupancy flags are decoded directly from sp.
  assign stk_full  = (sp == SP_W'(SDEPTH));
  assign stk_empty = (sp == '0);

  // Issue-qualified stack commands.
  assign do_push = iss_vld & push & ~src_sel;
  assign do_pop  = iss_vld & src_sel & ~push;
  assign do_rep  = iss_vld & push & src_sel;

  // Read the top entry. An empty stack returns zero, so the wrapped index
  // is never used.
  assign top_idx = SPTR'(sp - SP_W'(1));
  assign top_val = stk_empty ? '0 : stk_mem[top_idx];

  // Next-state logic for the stack pointer, the error flags and the write port.
  always_comb begin
    sp_nxt  = sp;
    ovf_nxt = stk_ovf;
    unf_nxt = stk_unf;
    wr_en   = 1'b0;
    wr_idx  = SPTR'(sp);
    in2_nxt = src_sel ? top_val : mem_in;

    if (do_push) begin
      if (stk_full) begin
        ovf_nxt = 1'b1;
      end else begin
        wr_en  = 1'b1;
        wr_idx = SPTR'(sp);
        sp_nxt = sp + SP_W'(1);
      end
    end

    if (do_pop) begin
      if (stk_empty) begin
        unf_nxt = 1'b1;
      end else begin
        sp_nxt = sp - SP_W'(1);
      end
    end

    // Replace-top: in2 reads the old top and acc overwrites that slot.
    // On an empty stack this becomes a plain push that also flags underflow.
    if (do_rep) begin
      wr_en = 1'b1;
      if (stk_empty) begin
        unf_nxt = 1'b1;
        wr_idx  = '0;
        sp_nxt  = SP_W'(1);
      end else begin
        wr_idx = top_idx;
      end
    end
  end

  // Operand issue registers. in1 takes acc as it was before any same-cycle
  // acc_wr.
  always_ff @(posedge clk) begin
    if (rst) begin
      op      <= '0;
      in1     <= '0;
      in2     <= '0;
      opr_vld <= 1'b0;
    end else begin
      opr_vld <= iss_vld;
      if (iss_vld) begin
        op  <= op_in;
        in1 <= acc;
        in2 <= in2_nxt;
      end
    end
  end

  // Accumulator capture from the ALU.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_zero <= 1'b1;
    end else if (acc_wr) begin
      acc      <= ula_out;
      acc_zero <= ula_zero;
    end
  end

  // Stack pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
    end else begin
      sp      <= sp_nxt;
      stk_ovf <= ovf_nxt;
      stk_unf <= unf_nxt;
    end
  end

  // Stack write port. Reset suppresses any write issued in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      stk_mem[wr_idx] <= acc;
    end
  end

`ifdef ULA_STK_HWM_EN
  // High-water mark. It follows sp one cycle late and never decreases.
  always_ff @(posedge clk) begin
    if (rst) begin
      stk_hwm <= '0;
    end else if (sp > stk_hwm) begin
      stk_hwm <= sp;
    end
  end
`endif

endmodule

// File: tb/tb_ula_opr_stage.sv
// Directed bench for ula_opr_stage. It uses the default parameters
// (32-bit word, SDEPTH=8).
module tb_ula_opr_stage;

  logic        clk;
  logic        rst;
  logic        iss_vld;
  logic [5:0]  op_in;
  logic        src_sel;
  logic [31:0] mem_in;
  logic        push;
  logic [31:0] ula_out;
  logic        ula_zero;
  logic        acc_wr;
  logic [5:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        opr_vld;
  logic [31:0] acc;
  logic        acc_zero;
  logic        stk_full;
  logic        stk_empty;
  logic        stk_ovf;
  logic        stk_unf;
`ifdef ULA_STK_HWM_EN
  logic [3:0]  stk_hwm;
`endif

  int total = 0;
  int bad   = 0;

  ula_opr_stage dut (
    .clk       (clk),
    .rst       (rst),
    .iss_vld   (iss_vld),
    .op_in     (op_in),
    .src_sel   (src_sel),
    .mem_in    (mem_in),
    .push      (push),
    .ula_out   (ula_out),
    .ula_zero  (ula_zero),
    .acc_wr    (acc_wr),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .opr_vld   (opr_vld),
    .acc       (acc),
    .acc_zero  (acc_zero),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
`ifdef ULA_STK_HWM_EN
    ,
    .stk_hwm   (stk_hwm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_vld = 1'b0; op_in = '0; src_sel = 1'b0; mem_in = '0;
    push = 1'b0; ula_out = '0; ula_zero = 1'b0; acc_wr = 1'b0;
  endtask

  task automatic load_acc(input logic [31:0] v);
    idle(); acc_wr = 1'b1; ula_out = v; tick(); idle();
  endtask

  task automatic do_push();
    idle(); iss_vld = 1'b1; push = 1'b1; tick(); idle();
  endtask

  task automatic do_pop();
    idle(); iss_vld = 1'b1; src_sel = 1'b1; tick(); idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;

    // Reset, then idle.
    tick(); tick();
    rst = 1'b0;
    tick();
    chk ("rst_op",    32'(op), 32'h0);
    chk ("rst_in1",   in1, 32'h0);
    chk ("rst_in2",   in2, 32'h0);
    chk1("rst_vld",   opr_vld, 1'b0);
    chk ("rst_acc",   acc, 32'h0);
    chk1("rst_accz",  acc_zero, 1'b1);
    chk1("rst_empty", stk_empty, 1'b1);
    chk1("rst_full",  stk_full, 1'b0);
    chk1("rst_ovf",   stk_ovf, 1'b0);
    chk1("rst_unf",   stk_unf, 1'b0);

    // Issue with a memory operand.
    load_acc(32'h3F800000);
    chk ("mem_acc",  acc, 32'h3F800000);
    chk1("mem_accz", acc_zero, 1'b0);
    iss_vld = 1'b1; op_in = 6'd2; src_sel = 1'b0; mem_in = 32'h40000000;
    tick(); idle();
    chk ("mem_op",  32'(op), 32'd2);
    chk ("mem_in1", in1, 32'h3F800000);
    chk ("mem_in2", in2, 32'h40000000);
    chk1("mem_vld", opr_vld, 1'b1);
    tick();
    chk1("hold_vld", opr_vld, 1'b0);
    chk ("hold_op",  32'(op), 32'd2);
    chk ("hold_in2", in2, 32'h40000000);

    // Push/pop round trip.
    load_acc(32'h40400000);
    do_push();
    chk1("rt_nempty", stk_empty, 1'b0);
    load_acc(32'h3F800000);
    iss_vld = 1'b1; op_in = 6'd3; src_sel = 1'b1;
    tick(); idle();
    chk ("rt_op",    32'(op), 32'd3);
    chk ("rt_in1",   in1, 32'h3F800000);
    chk ("rt_in2",   in2, 32'h40400000);
    chk1("rt_empty", stk_empty, 1'b1);

    // acc_wr in the same cycle as an issue: in1 takes the old acc.
    iss_vld = 1'b1; op_in = 6'd1; mem_in = 32'h00000005;
    acc_wr = 1'b1; ula_out = 32'h12345678; ula_zero = 1'b0;
    tick(); idle();
    chk ("same_in1", in1, 32'h3F800000);
    chk ("same_acc", acc, 32'h12345678);
    load_acc(32'h0);
    chk1("zero_flag", acc_zero, 1'b0);
    idle(); acc_wr = 1'b1; ula_out = 32'h0; ula_zero = 1'b1; tick(); idle();
    chk1("zero_flag1", acc_zero, 1'b1);

    // Overflow: nine pushes onto an 8-deep stack.
    for (int i = 0; i < 9; i++) begin
      load_acc(32'hA0000000 + 32'(i));
      do_push();
      if (i == 6) chk1("ovf_nfull7", stk_full, 1'b0);
      if (i == 7) begin
        chk1("ovf_full8", stk_full, 1'b1);
        chk1("ovf_flag8", stk_ovf, 1'b0);
      end
    end
    chk1("ovf_flag9", stk_ovf, 1'b1);
    chk1("ovf_full9", stk_full, 1'b1);
    for (int k = 0; k < 8; k++) begin
      do_pop();
      chk($sformatf("lifo_%0d", k), in2, 32'hA0000007 - 32'(k));
    end
    chk1("lifo_empty",  stk_empty, 1'b1);
    chk1("lifo_unf",    stk_unf, 1'b0);
    chk1("ovf_sticky",  stk_ovf, 1'b1);

    // Underflow, then replace-top.
    do_pop();
    chk ("unf_in2",  in2, 32'h0);
    chk1("unf_flag", stk_unf, 1'b1);
    load_acc(32'h41200000);
    do_push();
    load_acc(32'h41A00000);
    idle(); iss_vld = 1'b1; push = 1'b1; src_sel = 1'b1; tick(); idle();
    chk ("rep_in2",    in2, 32'h41200000);
    chk1("rep_nempty", stk_empty, 1'b0);
    do_pop();
    chk ("rep_pop",    in2, 32'h41A00000);
    chk1("rep_empty",  stk_empty, 1'b1);

    // Replace-top on an empty stack acts as a push.
    load_acc(32'h55AA55AA);
    idle(); iss_vld = 1'b1; push = 1'b1; src_sel = 1'b1; tick(); idle();
    chk ("repe_in2",    in2, 32'h0);
    chk1("repe_nempty", stk_empty, 1'b0);
    do_pop();
    chk ("repe_pop",    in2, 32'h55AA55AA);
    chk1("repe_empty",  stk_empty, 1'b1);

    // Reset in the middle of operation: sp=5 with stk_ovf still set.
    for (int i = 0; i < 5; i++) begin
      load_acc(32'hB0000000 + 32'(i));
      do_push();
    end
    chk1("pre_ovf", stk_ovf, 1'b1);
`ifdef ULA_STK_HWM_EN
    chk("pre_hwm", 32'(stk_hwm), 32'd8);
`endif
    rst = 1'b1; iss_vld = 1'b1; push = 1'b1; acc_wr = 1'b1; ula_out = 32'hDEADBEEF;
    tick();
    rst = 1'b0; idle();
    chk1("mrst_empty", stk_empty, 1'b1);
    chk1("mrst_ovf",   stk_ovf, 1'b0);
    chk1("mrst_unf",   stk_unf, 1'b0);
    chk1("mrst_vld",   opr_vld, 1'b0);
    chk ("mrst_acc",   acc, 32'h0);
    chk1("mrst_accz",  acc_zero, 1'b1);
    chk ("mrst_in2",   in2, 32'h0);
`ifdef ULA_STK_HWM_EN
    chk("mrst_hwm", 32'(stk_hwm), 32'd0);
`endif
    tick();
    chk1("post_empty", stk_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ula_opr_stage.md
Name: ula_opr_stage

Overview:
- Operand-issue stage directly upstream of the processor ALU (floating-point/integer ALU with 6-bit op, in1/in2, out and is_zero).
- Holds the accumulator and the expression operand stack.
- Registers op/in1/in2 toward the ALU; captures the ALU result and zero flag back into the accumulator.
- Handles push/pop of partial results for nested expressions, with sticky overflow/underflow error flags.

Parameters:
- EXP, 8, exponent width; data word is MAN+EXP+1 bits.
- MAN, 23, mantissa width.
- SDEPTH, 8, operand stack depth in words (2..64).
- SPTR, 3, stack pointer width; must satisfy 2^SPTR >= SDEPTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- iss_vld  in  1  decoder issues an instruction this cycle.
- op_in  in  6  ALU opcode to issue (0..23, ALU encoding).
- src_sel  in  1  in2 source: 0 = mem_in, 1 = pop stack top.
- mem_in  in  MAN+EXP+1  memory/immediate operand.
- push  in  1  push current acc onto stack (qualified by iss_vld).
- ula_out  in  MAN+EXP+1  ALU result.
- ula_zero  in  1  ALU is_zero.
- acc_wr  in  1  capture ula_out/ula_zero into acc this cycle.
- op  out  6  registered opcode to ALU.
- in1  out  MAN+EXP+1  registered first operand (acc).
- in2  out  MAN+EXP+1  registered second operand.
- opr_vld  out  1  op/in1/in2 valid.
- acc  out  MAN+EXP+1  accumulator.
- acc_zero  out  1  registered zero flag of acc.
- stk_full  out  1  stack pointer == SDEPTH.
- stk_empty  out  1  stack pointer == 0.
- stk_ovf  out  1  sticky push-on-full error.
- stk_unf  out  1  sticky pop-on-empty error.

Behaviour:
- Reset (rst=1 at edge):
  - op=0 (NOP), in1=0, in2=0, opr_vld=0, acc=0, acc_zero=1.
  - Stack pointer sp=0, so stk_empty=1, stk_full=0.
  - stk_ovf=0, stk_unf=0.
  - Stack RAM contents are don't-care.
  - rst overrides every other input, including mid-push or mid-pop.
- Issue: latency 1.
  - On an iss_vld edge: op<=op_in; in1<=acc (value before any acc_wr in the same cycle); in2<=(src_sel ? stack[sp-1] : mem_in); opr_vld<=1.
  - Without iss_vld: opr_vld<=0; op/in1/in2 hold.
- Accumulator:
  - acc_wr edge: acc<=ula_out, acc_zero<=ula_zero.
  - acc_wr is independent of iss_vld; the same-cycle issue still sees the old acc.
- Push (iss_vld&push&!(src_sel)):
  - not full: stack[sp]<=acc, sp<=sp+1.
  - full: write dropped, sp holds, stk_ovf<=1.
- Pop (iss_vld&src_sel&!push):
  - not empty: sp<=sp-1.
  - empty: in2<=0, sp holds, stk_unf<=1.
- Simultaneous push+pop (iss_vld&push&src_sel):
  - not empty: in2<=old top, then stack[sp-1]<=acc; sp unchanged (replace-top).
  - empty: treated as a plain push; in2<=0, stk_unf<=1, stack[0]<=acc, sp<=1.
- sp never wraps; it is bounded to 0..SDEPTH.
- stk_full and stk_empty are combinational from sp.
- stk_ovf and stk_unf clear only on rst.
- Arithmetic: no data transformation; words pass bit-exact.

Optional Feature:
- ULA_STK_HWM_EN defined: adds output stk_hwm [SPTR:0].
  - Holds the maximum sp reached since reset; reset value 0.
  - Updates the cycle after sp rises above it.
  - Never decreases.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then iss_vld=0 -> op=0, in1=0, in2=0, acc_zero=1, stk_empty=1, opr_vld=0, flags 0.
- Memory-operand issue: acc_wr with ula_out=32'h3F800000 (1.0); next cycle iss_vld, op_in=2, src_sel=0, mem_in=32'h40000000 -> one cycle later op=2, in1=32'h3F800000, in2=32'h40000000, opr_vld=1.
- Push/pop round trip: acc=32'h40400000, push; acc_wr to 32'h3F800000; issue op_in=3 with src_sel=1 -> in1=32'h3F800000, in2=32'h40400000; sp returns to 0, stk_empty=1.
- Overflow: 9 consecutive pushes with SDEPTH=8 -> stk_full=1 after the 8th; stk_ovf=1 after the 9th; sp stays 8; 8 pops return values in LIFO order.
- Underflow plus replace-top: pop on empty -> in2=0, stk_unf=1. Then push A=32'h41200000, then push+pop with acc=B=32'h41A00000 -> in2=A, sp=1, next pop yields B.
- Reset mid-operation: sp=5, stk_ovf=1, and iss_vld+push asserted in the same cycle as rst -> sp=0, stk_ovf=0, opr_vld=0, no stack write; with ULA_STK_HWM_EN, stk_hwm=0.
